// File: rtl/game_pkg.sv
// Shared game-level types and constants used by the sprite/projectile blocks.
package game_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int COORD_W = 10;

    typedef struct packed {
        logic               active;
        logic               dir;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } bullet_slot_t;

endpackage

// File: rtl/bullet_sprite_mask.sv
// Rounded-square bullet sprite: maps a sprite-relative offset (dx, dy) to an on bit.
module bullet_sprite_mask #(
    parameter int SPR_W = 6,
    parameter int SPR_H = 6,
    parameter int CUT   = 2,
    parameter int DX_W  = 11,
    parameter int DY_W  = 11
) (
    input  logic [DX_W-1:0] dx,
    input  logic [DY_W-1:0] dy,
    output logic            on
);

    int ix, iy, ex, ey;

    // Offsets arrive as unsigned wrap-around differences, so a negative
    // offset shows up as a huge value and fails the range check.
    always_comb begin
        ix = int'(dx);
        iy = int'(dy);
        ex = (ix < SPR_W - 1 - ix) ? ix : SPR_W - 1 - ix;
        ey = (iy < SPR_H - 1 - iy) ? iy : SPR_H - 1 - iy;
        on = (ix < SPR_W) && (iy < SPR_H) && (ex + ey >= CUT);
    end

endmodule

// File: rtl/bullet_pool.sv
// Projectile pool: slot allocation, per-frame movement, kills and a
// registered per-pixel "bullet here" answer for the scan-out path.
module bullet_pool
    import game_pkg::*;
#(
    parameter int N_BULLETS = 4,
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int SPR_W     = 6,
    parameter int SPR_H     = 6,
    parameter int CUT       = 2,
    parameter int SPEED     = 2,
    parameter int SCREEN_H  = game_pkg::SCREEN_H,
    localparam int IDX_W    = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fire_req,
    input  logic [X_W-1:0]       fire_x,
    input  logic [Y_W-1:0]       fire_y,
    input  logic                 fire_dir,
    output logic                 fire_ack,
    output logic [IDX_W-1:0]     fire_slot,
    output logic                 full,
    input  logic                 frame_tick,
    input  logic                 kill_req,
    input  logic [IDX_W-1:0]     kill_idx,
    input  logic                 pix_en,
    input  logic [X_W-1:0]       px,
    input  logic [Y_W-1:0]       py,
    output logic                 pix_on,
    output logic [N_BULLETS-1:0] active
);

    localparam logic [Y_W:0] Y_STEP = (Y_W+1)'(SPEED);
    localparam logic [Y_W:0] Y_LIM  = (Y_W+1)'(SCREEN_H - SPR_H);

    logic [N_BULLETS-1:0]          act_q, act_d;
    logic [N_BULLETS-1:0]          dir_q, dir_d;
    logic [N_BULLETS-1:0][X_W-1:0] x_q, x_d;
    logic [N_BULLETS-1:0][Y_W-1:0] y_q, y_d;
    logic [N_BULLETS-1:0]          hit;

    logic             free_any;
    logic             grant;
    logic [IDX_W-1:0] grant_idx;

    // Lowest-index free slot; scanning downward leaves the smallest index last.
    always_comb begin
        free_any  = 1'b0;
        grant_idx = '0;
        for (int i = N_BULLETS - 1; i >= 0; i--) begin
            if (!act_q[i]) begin
                free_any  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end

    assign grant = fire_req && free_any;

    // A freshly granted slot was inactive, so neither a kill nor a tick can
    // touch it this cycle; kill outranks movement on live slots.
    always_comb begin
        act_d = act_q;
        dir_d = dir_q;
        x_d   = x_q;
        y_d   = y_q;
        for (int i = 0; i < N_BULLETS; i++) begin
            if (grant && grant_idx == IDX_W'(i)) begin
                act_d[i] = 1'b1;
                dir_d[i] = fire_dir;
                x_d[i]   = fire_x;
                y_d[i]   = fire_y;
            end else if (kill_req && kill_idx == IDX_W'(i)) begin
                act_d[i] = 1'b0;
            end else if (frame_tick && act_q[i]) begin
                if (dir_q[i] == DIR_DOWN) begin
                    if ({1'b0, y_q[i]} + Y_STEP > Y_LIM)
                        act_d[i] = 1'b0;
                    else
                        y_d[i] = y_q[i] + Y_W'(SPEED);
                end else if (dir_q[i] == DIR_UP && {1'b0, y_q[i]} < Y_STEP) begin
                    act_d[i] = 1'b0;
                end else begin
                    y_d[i] = y_q[i] - Y_W'(SPEED);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q     <= '0;
            dir_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            fire_ack  <= 1'b0;
            fire_slot <= '0;
            pix_on    <= 1'b0;
        end else begin
            act_q     <= act_d;
            dir_q     <= dir_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fire_ack  <= grant;
            fire_slot <= grant ? grant_idx : '0;
            pix_on    <= pix_en && |(hit & act_q);
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_BULLETS; g++) begin : g_slot
            logic [X_W:0] dx;
            logic [Y_W:0] dy;

            assign dx = {1'b0, px} - {1'b0, x_q[g]};
            assign dy = {1'b0, py} - {1'b0, y_q[g]};

            bullet_sprite_mask #(
                .SPR_W (SPR_W),
                .SPR_H (SPR_H),
                .CUT   (CUT),
                .DX_W  (X_W + 1),
                .DY_W  (Y_W + 1)
            ) u_mask (
                .dx (dx),
                .dy (dy),
                .on (hit[g])
            );
        end
    endgenerate

    assign active = act_q;
    assign full   = &act_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Directed vector bench for bullet_pool: one vector per clock, plus an async-reset sequence.
module tb_bullet_pool;

    logic       clk = 1'b0;
    logic       rst;
    logic       fire_req;
    logic [9:0] fire_x;
    logic [9:0] fire_y;
    logic       fire_dir;
    logic       fire_ack;
    logic [1:0] fire_slot;
    logic       full;
    logic       frame_tick;
    logic       kill_req;
    logic [1:0] kill_idx;
    logic       pix_en;
    logic [9:0] px;
    logic [9:0] py;
    logic       pix_on;
    logic [3:0] active;

    int ncmp = 0;
    int nerr = 0;

    bullet_pool dut (
        .clk        (clk),
        .rst        (rst),
        .fire_req   (fire_req),
        .fire_x     (fire_x),
        .fire_y     (fire_y),
        .fire_dir   (fire_dir),
        .fire_ack   (fire_ack),
        .fire_slot  (fire_slot),
        .full       (full),
        .frame_tick (frame_tick),
        .kill_req   (kill_req),
        .kill_idx   (kill_idx),
        .pix_en     (pix_en),
        .px         (px),
        .py         (py),
        .pix_on     (pix_on),
        .active     (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fire;
        logic [9:0] fx;
        logic [9:0] fy;
        logic       fd;
        logic       tick;
        logic       kill;
        logic [1:0] ki;
        logic       pe;
        logic [9:0] qx;
        logic [9:0] qy;
        logic       ack;
        logic [1:0] slot;
        logic [3:0] act;
        logic       pix;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic f, logic [9:0] fx, logic [9:0] fy, logic fd,
                                logic tk, logic kl, logic [1:0] ki,
                                logic pe, logic [9:0] qx, logic [9:0] qy,
                                logic ack, logic [1:0] sl, logic [3:0] act, logic pix);
        vec_t v;
        v.fire = f;  v.fx = fx; v.fy = fy; v.fd = fd;
        v.tick = tk; v.kill = kl; v.ki = ki;
        v.pe = pe;   v.qx = qx; v.qy = qy;
        v.ack = ack; v.slot = sl; v.act = act; v.pix = pix;
        return v;
    endfunction

    function automatic vec_t vf(logic [9:0] x, logic [9:0] y, logic d, logic ack, logic [1:0] sl, logic [3:0] act);
        return mk(1'b1, x, y, d, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 10'd0, ack, sl, act, 1'b0);
    endfunction

    function automatic vec_t vqr(logic [9:0] x, logic [9:0] y, logic [3:0] act, logic pix);
        return mk(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, x, y, 1'b0, 2'd0, act, pix);
    endfunction

    function automatic vec_t vt(logic [3:0] act);
        return mk(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 10'd0, 10'd0, 1'b0, 2'd0, act, 1'b0);
    endfunction

    function automatic vec_t vk(logic [1:0] i, logic [3:0] act);
        return mk(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, i, 1'b0, 10'd0, 10'd0, 1'b0, 2'd0, act, 1'b0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        ncmp++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic idle_inputs();
        fire_req = 1'b0; fire_x = '0; fire_y = '0; fire_dir = 1'b0;
        frame_tick = 1'b0; kill_req = 1'b0; kill_idx = '0;
        pix_en = 1'b0; px = '0; py = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // Fill, overflow, kill-during-full, tick with pre-update query.
        vq.push_back(vf(10'd100, 10'd200, 1'b0, 1'b1, 2'd0, 4'b0001));
        vq.push_back(vf(10'd100, 10'd200, 1'b0, 1'b1, 2'd1, 4'b0011));
        vq.push_back(vf(10'd100, 10'd200, 1'b0, 1'b1, 2'd2, 4'b0111));
        vq.push_back(vf(10'd100, 10'd200, 1'b0, 1'b1, 2'd3, 4'b1111));
        vq.push_back(vf(10'd100, 10'd200, 1'b0, 1'b0, 2'd0, 4'b1111));
        vq.push_back(mk(1'b1, 10'd100, 10'd200, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 10'd0, 10'd0, 1'b0, 2'd0, 4'b0111, 1'b0));
        vq.push_back(vqr(10'd102, 10'd200, 4'b0111, 1'b1));
        vq.push_back(vqr(10'd102, 10'd199, 4'b0111, 1'b0));
        vq.push_back(mk(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 10'd102, 10'd200, 1'b0, 2'd0, 4'b0111, 1'b1));
        vq.push_back(vqr(10'd102, 10'd198, 4'b0111, 1'b1));
        vq.push_back(vqr(10'd102, 10'd204, 4'b0111, 1'b0));
        vq.push_back(vk(2'd0, 4'b0110));
        vq.push_back(vk(2'd0, 4'b0110));
        vq.push_back(vk(2'd1, 4'b0100));
        vq.push_back(vk(2'd2, 4'b0000));
        // Top and bottom exits.
        vq.push_back(vf(10'd10, 10'd3, 1'b0, 1'b1, 2'd0, 4'b0001));
        vq.push_back(vt(4'b0001));
        vq.push_back(vqr(10'd12, 10'd1, 4'b0001, 1'b1));
        vq.push_back(vqr(10'd12, 10'd0, 4'b0001, 1'b0));
        vq.push_back(vt(4'b0000));
        vq.push_back(vf(10'd10, 10'd472, 1'b1, 1'b1, 2'd0, 4'b0001));
        vq.push_back(vt(4'b0001));
        vq.push_back(vqr(10'd12, 10'd474, 4'b0001, 1'b1));
        vq.push_back(vqr(10'd12, 10'd473, 4'b0001, 1'b0));
        vq.push_back(vt(4'b0000));
        // Fire + tick + kill in one cycle.
        vq.push_back(vf(10'd200, 10'd100, 1'b1, 1'b1, 2'd0, 4'b0001));
        vq.push_back(vf(10'd300, 10'd100, 1'b1, 1'b1, 2'd1, 4'b0011));
        vq.push_back(mk(1'b1, 10'd400, 10'd100, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 10'd0, 10'd0, 1'b1, 2'd2, 4'b0110, 1'b0));
        vq.push_back(vqr(10'd402, 10'd100, 4'b0110, 1'b1));
        vq.push_back(vqr(10'd402, 10'd98, 4'b0110, 1'b0));
        vq.push_back(vqr(10'd302, 10'd102, 4'b0110, 1'b1));
        vq.push_back(vqr(10'd302, 10'd101, 4'b0110, 1'b0));
        vq.push_back(vqr(10'd202, 10'd102, 4'b0110, 1'b0));
        vq.push_back(vk(2'd1, 4'b0100));
        vq.push_back(vk(2'd2, 4'b0000));
        // Sprite mask, latency, overlap and pix_en gating.
        vq.push_back(vf(10'd50, 10'd60, 1'b0, 1'b1, 2'd0, 4'b0001));
        vq.push_back(vqr(10'd50, 10'd60, 4'b0001, 1'b0));
        vq.push_back(vqr(10'd52, 10'd60, 4'b0001, 1'b1));
        vq.push_back(vqr(10'd51, 10'd61, 4'b0001, 1'b1));
        vq.push_back(vt(4'b0001));
        vq.push_back(vqr(10'd56, 10'd60, 4'b0001, 1'b0));
        vq.push_back(vf(10'd52, 10'd60, 1'b0, 1'b1, 2'd1, 4'b0011));
        vq.push_back(vqr(10'd53, 10'd61, 4'b0011, 1'b1));
        vq.push_back(mk(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 10'd53, 10'd61, 1'b0, 2'd0, 4'b0011, 1'b0));
        vq.push_back(vqr(10'd57, 10'd62, 4'b0011, 1'b1));

        repeat (2) @(negedge clk);
        chk("reset active", 32'(active), 32'h0);
        chk("reset fire_ack", 32'(fire_ack), 32'h0);
        chk("reset fire_slot", 32'(fire_slot), 32'h0);
        chk("reset pix_on", 32'(pix_on), 32'h0);
        chk("reset full", 32'(full), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            fire_req = vq[i].fire; fire_x = vq[i].fx; fire_y = vq[i].fy; fire_dir = vq[i].fd;
            frame_tick = vq[i].tick; kill_req = vq[i].kill; kill_idx = vq[i].ki;
            pix_en = vq[i].pe; px = vq[i].qx; py = vq[i].qy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d fire_ack", i), 32'(fire_ack), 32'(vq[i].ack));
            if (vq[i].ack)
                chk($sformatf("v%0d fire_slot", i), 32'(fire_slot), 32'(vq[i].slot));
            chk($sformatf("v%0d active", i), 32'(active), 32'(vq[i].act));
            chk($sformatf("v%0d full", i), 32'(full), 32'(&vq[i].act));
            chk($sformatf("v%0d pix_on", i), 32'(pix_on), 32'(vq[i].pix));
        end

        // Third bullet plus a live hit, then an async reset between edges.
        @(negedge clk);
        idle_inputs();
        fire_req = 1'b1; fire_x = 10'd50; fire_y = 10'd60;
        pix_en = 1'b1; px = 10'd53; py = 10'd61;
        @(posedge clk);
        #1;
        chk("pre-reset fire_ack", 32'(fire_ack), 32'h1);
        chk("pre-reset fire_slot", 32'(fire_slot), 32'h2);
        chk("pre-reset active", 32'(active), 32'h7);
        chk("pre-reset pix_on", 32'(pix_on), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async rst active", 32'(active), 32'h0);
        chk("async rst pix_on", 32'(pix_on), 32'h0);
        chk("async rst fire_ack", 32'(fire_ack), 32'h0);
        chk("async rst full", 32'(full), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        fire_req = 1'b1; fire_x = 10'd5; fire_y = 10'd5;
        pix_en = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset fire_ack", 32'(fire_ack), 32'h1);
        chk("post-reset fire_slot", 32'(fire_slot), 32'h0);
        chk("post-reset active", 32'(active), 32'h1);
        @(negedge clk);
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/bullet_pool.md
Name: bullet_pool

Overview:
- Owns every live projectile on screen. It holds N_BULLETS slots, each with a position, a direction and an active flag.
- It accepts fire requests from the player and enemy logic, moves bullets on each frame tick, and retires bullets that leave the playfield or are killed by collision logic.
- It answers per-pixel queries from the VGA scan path with a registered "bullet pixel on" bit. The bullet sprite is a parametrised rounded square.

Parameters:
- N_BULLETS, 4, number of bullet slots (1..16)
- X_W, 10, width of X coordinates
- Y_W, 10, width of Y coordinates
- SPR_W, 6, sprite width in pixels
- SPR_H, 6, sprite height in pixels
- CUT, 2, corner rounding: a sprite pixel is off when min(dx,SPR_W-1-dx)+min(dy,SPR_H-1-dy) < CUT
- SPEED, 2, pixels moved per frame_tick
- SCREEN_H, 480, playfield height in pixels

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- fire_req  in  1  request to spawn a bullet
- fire_x  in  X_W  spawn X (top-left corner of sprite)
- fire_y  in  Y_W  spawn Y (top-left corner of sprite)
- fire_dir  in  1  0 = moving up (Y decreases), 1 = moving down
- fire_ack  out  1  one-cycle pulse when a fire request is accepted
- fire_slot  out  $clog2(N_BULLETS)  slot index granted, valid while fire_ack=1
- full  out  1  all slots active
- frame_tick  in  1  one-cycle pulse, once per frame
- kill_req  in  1  retire one slot
- kill_idx  in  $clog2(N_BULLETS)  slot to retire
- pix_en  in  1  pixel query valid
- px  in  X_W  query X
- py  in  Y_W  query Y
- pix_on  out  1  registered query result
- active  out  N_BULLETS  per-slot active flags

Behaviour:
- Reset (asynchronous, active-high): all slot registers cleared, including active. fire_ack=0, fire_slot=0, pix_on=0, full=0.
- Fire request handling:
  - Accepted in cycle t if fire_req=1 and at least one slot is free, using the free set sampled at t (before any kill at t).
  - The granted slot is the lowest-index free slot. It loads x, y and dir, and active=1 at t+1.
  - fire_ack=1 and fire_slot=index are registered and appear at t+1.
- Full pool: fire_req while full produces no ack and no state change. The request is dropped, not queued; the requester re-asserts if it still wants the bullet.
- Kill:
  - kill_req clears active[kill_idx] at t+1.
  - Killing an inactive slot has no effect.
  - A slot freed by a kill is not grantable in the same cycle.
- frame_tick: every slot active at t moves by SPEED:
  - dir=0: if y < SPEED, the slot deactivates; otherwise y = y - SPEED.
  - dir=1: if y + SPEED > SCREEN_H - SPR_H, the slot deactivates; otherwise y = y + SPEED.
  - x never changes.
- Simultaneous events in one cycle:
  - A bullet spawned in cycle t is not moved by a frame_tick in cycle t. It first moves on the next tick.
  - kill_req and frame_tick on the same slot: the kill wins and the slot ends inactive.
- Pixel query path:
  - For each active slot, dx = px - x and dy = py - y, computed unsigned at X_W+1 and Y_W+1 bits.
  - The slot hits when 0 <= dx < SPR_W, 0 <= dy < SPR_H, and the sprite mask bit at (dx, dy) is 1.
  - pix_on(t+1) = pix_en(t) AND (OR of all slot hits at t). Latency is one cycle.
  - The query uses slot state before any same-cycle update.
- Outputs: full = AND of active (combinational from registers). active is driven directly from the slot registers.
- Reference shape: with SPR_W=SPR_H=6 and CUT=2 the mask rows are 001100, 011110, 111111, 111111, 011110, 001100.

Decomposition:
- Shared package game_pkg:
  - DIR_UP=1'b0, DIR_DOWN=1'b1.
  - Default screen dimensions (SCREEN_W=640, SCREEN_H=480).
  - Bullet slot struct {active, dir, x, y}.
- Sub-module bullet_sprite_mask:
  - Purely combinational, parametrised by SPR_W, SPR_H, CUT.
  - Maps (dx, dy) to a mask bit.
  - Instantiated once per slot through a generate loop.
- Slot allocation is a lowest-index priority encoder inside bullet_pool.

Test Plan:
- Reset mid-operation: 3 active slots, assert rst for 1 cycle -> active=0000, pix_on=0, fire_ack=0 immediately (asynchronous).
- Fill and overflow: 5 back-to-back fire_req (x=100, y=200, dir=0) -> acks with fire_slot 0,1,2,3; full=1 after the 4th; 5th gets no ack and active stays 1111.
- Movement and exit:
  - Slot at y=3, dir=0, SPEED=2 -> after one tick y=1, after the next tick active=0.
  - Slot at y=472, dir=1 -> after one tick y=474; after the next tick 476 > 474, so it retires.
- Simultaneous fire + tick + kill: slots 0 and 1 active, then kill_idx=0, fire_req and frame_tick in the same cycle -> new bullet in slot 2 with unmoved y; slot 0 inactive; slot 1 moved by 2.
- Pixel mask: bullet at (50,60); query (50,60) -> pix_on=0; (52,60) -> 1; (51,61) -> 1; (56,62) -> 0; each result appears exactly one cycle after pix_en.
- Overlap and pix_en gating: two bullets overlapping at (53,63) -> pix_on=1; the same query with pix_en=0 -> pix_on=0.
